// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    function automatic logic op_a_signed(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/adder_nb.sv
// Plain N-bit adder with carry-in; subtraction is done by the caller
// inverting the second operand and setting cin.
module adder_nb #(
    parameter int unsigned WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// division, one bit per cycle on a single shared 33-bit adder.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rslt
);

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     acc_q, acc_d;      // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;        // multiplier / dividend -> quotient
    logic [XLEN-1:0]   opb_q, opb_d;      // multiplicand / divisor magnitude
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   rslt_q, rslt_d;

    logic [XLEN:0]     add_a, add_b, add_sum;
    logic              add_cin;

    muldiv_op_t        op_in;
    logic              sa, sb, div0, ovf, special;
    logic [XLEN-1:0]   mag_a, mag_b, spec_rslt;

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, fix_rslt;

    adder_nb #(.WIDTH(XLEN + 1)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    // Divide uses the adder as a trial subtract of the divisor from the
    // left-shifted remainder; multiply adds the multiplicand when lo[0]=1.
    always_comb begin
        if (op_q[2]) begin
            add_a   = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
            add_b   = ~{1'b0, opb_q};
            add_cin = 1'b1;
        end else begin
            add_a   = acc_q;
            add_b   = lo_q[0] ? {1'b0, opb_q} : '0;
            add_cin = 1'b0;
        end
    end

    always_comb begin
        op_in     = muldiv_op_t'(op);
        sa        = op_a_signed(op_in) & a[XLEN-1];
        sb        = op_b_signed(op_in) & b[XLEN-1];
        mag_a     = sa ? -a : a;
        mag_b     = sb ? -b : b;
        div0      = op_in[2] && (b == '0);
        ovf       = (op_in == OP_DIV || op_in == OP_REM) && (a == INT_MIN) && (b == DIV0_QUOT);
        special   = div0 | ovf;
        if (div0) begin
            spec_rslt = op_in[1] ? a : DIV0_QUOT;
        end else begin
            spec_rslt = op_in[1] ? '0 : INT_MIN;
        end
    end

    always_comb begin
        prod   = {acc_q[XLEN-1:0], lo_q};
        prod_s = neg_q ? -prod : prod;
        quot_s = neg_q ? -lo_q : lo_q;
        rem_s  = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        case (op_q)
            OP_MUL:                       fix_rslt = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_rslt = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_rslt = quot_s;
            default:                      fix_rslt = rem_s;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        rslt_d  = rslt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    op_d   = op_in;
                    neg_d  = sa ^ sb;
                    rneg_d = sa;
                    acc_d  = '0;
                    lo_d   = mag_a;
                    opb_d  = mag_b;
                    cnt_d  = '1;
                    if (special) begin
                        rslt_d  = spec_rslt;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                busy_d = 1'b1;
                if (op_q[2]) begin
                    if (!add_sum[XLEN]) begin
                        acc_d = add_sum;
                        lo_d  = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = add_a;
                        lo_d  = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {1'b0, add_sum[XLEN:1]};
                    lo_d  = {add_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                rslt_d  = fix_rslt;
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rslt_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rslt_q  <= rslt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign rslt = rslt_q;

endmodule
